control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cpu_pkg.sv | 60 ++++++
 rtl/control_sequencer_if.sv | 46 ++++
 rtl/reg_decode.sv | 14 +
 rtl/control_sequencer.sv | 149 ++++++++++++++
 tb/tb_control_sequencer.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer states, opcodes and ALU select codes.
// Used by the control sequencer and by the datapath ALU.
package cpu_pkg;

   typedef enum logic [2:0] {
      T0, T1, T2, T3, T4, T5, T6, HALT
   } state_t;

   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_SUB = 5'b00100;
   localparam logic [4:0] OP_AND = 5'b00101;
   localparam logic [4:0] OP_OR  = 5'b00110;
   localparam logic [4:0] OP_SHR = 5'b00111;
   localparam logic [4:0] OP_SHL = 5'b01000;
   localparam logic [4:0] OP_MUL = 5'b01111;
   localparam logic [4:0] OP_DIV = 5'b10000;

   localparam logic [3:0] ALU_NONE = 4'b0000;
   localparam logic [3:0] ALU_ADD  = 4'b0001;
   localparam logic [3:0] ALU_SUB  = 4'b0010;
   localparam logic [3:0] ALU_AND  = 4'b0110;
   localparam logic [3:0] ALU_OR   = 4'b0111;
   localparam logic [3:0] ALU_SHR  = 4'b1000;
   localparam logic [3:0] ALU_SHL  = 4'b1001;
   localparam logic [3:0] ALU_MUL  = 4'b1010;
   localparam logic [3:0] ALU_DIV  = 4'b1011;

   function automatic logic is_alu_op(
      input logic [4:0] op
   );
      return op inside {OP_ADD, OP_SUB, OP_AND,
                        OP_OR, OP_SHR, OP_SHL};
   endfunction

   function automatic logic is_md_op(
      input logic [4:0] op
   );
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   function automatic logic [3:0] alu_code(
      input logic [4:0] op
   );
      logic [3:0] code;
      code = ALU_NONE;
      unique case (op)
         OP_ADD:  code = ALU_ADD;
         OP_SUB:  code = ALU_SUB;
         OP_AND:  code = ALU_AND;
         OP_OR:   code = ALU_OR;
         OP_SHR:  code = ALU_SHR;
         OP_SHL:  code = ALU_SHL;
         OP_MUL:  code = ALU_MUL;
         OP_DIV:  code = ALU_DIV;
         default: code = ALU_NONE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: IR/Stop in, control strobes out.
// master = sequencer side, slave = datapath side.
interface control_sequencer_if;

   logic [31:0] IR;
   logic        Stop;
   logic [15:0] Rin;
   logic [15:0] Rout;
   logic        PCin;
   logic        PCout;
   logic        IRin;
   logic        Yin;
   logic        Zin;
   logic        MARin;
   logic        MDRin;
   logic        MDRout;
   logic        HIin;
   logic        HIout;
   logic        LOin;
   logic        LOout;
   logic        IncPC;
   logic        Zhighout;
   logic        Zlowout;
   logic        Read;
   logic [3:0]  ALUselect;
   logic        Run;

   modport master (
      input  IR, Stop,
      output Rin, Rout, PCin, PCout, IRin,
      output Yin, Zin, MARin, MDRin, MDRout,
      output HIin, HIout, LOin, LOout, IncPC,
      output Zhighout, Zlowout, Read,
      output ALUselect, Run
   );

   modport slave (
      output IR, Stop,
      input  Rin, Rout, PCin, PCout, IRin,
      input  Yin, Zin, MARin, MDRin, MDRout,
      input  HIin, HIout, LOin, LOout, IncPC,
      input  Zhighout, Zlowout, Read,
      input  ALUselect, Run
   );

endinterface

// File: rtl/reg_decode.sv
// 4-to-16 one-hot register select decoder with enable.
module reg_decode (
   input  logic        en,
   input  logic [3:0]  sel,
   output logic [15:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en)
         onehot[sel] = 1'b1;
   end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch T0-T2, execute T3-T6, HALT on Stop.
// Optional mul/div execution is built when MULDIV_EN is defined.
module control_sequencer (
   input logic                 clock,
   input logic                 clear,
   control_sequencer_if.master bus
);

   import cpu_pkg::*;

   state_t     state;
   state_t     next;
   logic [4:0] op;
   logic [3:0] ra;
   logic [3:0] rb;
   logic [3:0] rc;
   logic       alu_op;
   logic       md_op;
   logic       rin_en;
   logic [3:0] rin_sel;
   logic       rout_en;
   logic [3:0] rout_sel;
   logic       unused_ir;

   assign op        = bus.IR[31:27];
   assign ra        = bus.IR[26:23];
   assign rb        = bus.IR[22:19];
   assign rc        = bus.IR[18:15];
   assign unused_ir = ^bus.IR[14:0];
   assign alu_op    = is_alu_op(op);

`ifdef MULDIV_EN
   assign md_op = is_md_op(op);
`else
   assign md_op = 1'b0;
`endif

   always_ff @(posedge clock or posedge clear) begin
      if (clear)
         state <= T0;
      else
         state <= next;
   end

   // T2 branch reads the IR presented by the datapath
   always_comb begin
      next = state;
      unique case (state)
         T0: next = T1;
         T1: next = T2;
         T2: begin
            if (bus.Stop)
               next = HALT;
            else if (alu_op || md_op)
               next = T3;
            else
               next = T0;
         end
         T3:   next = T4;
         T4:   next = T5;
         T5:   next = md_op ? T6 : T0;
         T6:   next = T0;
         HALT: next = HALT;
         default: next = T0;
      endcase
   end

   always_comb begin
      rin_en        = 1'b0;
      rin_sel       = 4'd0;
      rout_en       = 1'b0;
      rout_sel      = 4'd0;
      bus.PCin      = 1'b0;
      bus.PCout     = 1'b0;
      bus.IRin      = 1'b0;
      bus.Yin       = 1'b0;
      bus.Zin       = 1'b0;
      bus.MARin     = 1'b0;
      bus.MDRin     = 1'b0;
      bus.MDRout    = 1'b0;
      bus.HIin      = 1'b0;
      bus.HIout     = 1'b0;
      bus.LOin      = 1'b0;
      bus.LOout     = 1'b0;
      bus.IncPC     = 1'b0;
      bus.Zhighout  = 1'b0;
      bus.Zlowout   = 1'b0;
      bus.Read      = 1'b0;
      bus.ALUselect = ALU_NONE;
      bus.Run       = 1'b1;
      unique case (state)
         T0: begin
            bus.PCout = 1'b1;
            bus.MARin = 1'b1;
            bus.IncPC = 1'b1;
            bus.Zin   = 1'b1;
         end
         T1: begin
            bus.Zlowout = 1'b1;
            bus.PCin    = 1'b1;
            bus.Read    = 1'b1;
            bus.MDRin   = 1'b1;
         end
         T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
         end
         T3: begin
            rout_en  = 1'b1;
            rout_sel = md_op ? ra : rb;
            bus.Yin  = 1'b1;
         end
         T4: begin
            rout_en       = 1'b1;
            rout_sel      = md_op ? rb : rc;
            bus.Zin       = 1'b1;
            bus.ALUselect = alu_code(op);
         end
         T5: begin
            bus.Zlowout = 1'b1;
            if (md_op) begin
               bus.LOin = 1'b1;
            end else begin
               rin_en  = 1'b1;
               rin_sel = ra;
            end
         end
         T6: begin
            bus.Zhighout = 1'b1;
            bus.HIin     = 1'b1;
         end
         HALT: bus.Run = 1'b0;
         default: bus.Run = 1'b1;
      endcase
   end

   reg_decode u_rin (
      .en     (rin_en),
      .sel    (rin_sel),
      .onehot (bus.Rin)
   );

   reg_decode u_rout (
      .en     (rout_en),
      .sel    (rout_sel),
      .onehot (bus.Rout)
   );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: ALU ops, NOP, Stop/HALT, clear.
// Build with +define+MULDIV_EN to exercise the mul/div path.
module tb_control_sequencer;

   localparam logic [15:0] F_PCIN   = 16'h8000;
   localparam logic [15:0] F_PCOUT  = 16'h4000;
   localparam logic [15:0] F_IRIN   = 16'h2000;
   localparam logic [15:0] F_YIN    = 16'h1000;
   localparam logic [15:0] F_ZIN    = 16'h0800;
   localparam logic [15:0] F_MARIN  = 16'h0400;
   localparam logic [15:0] F_MDRIN  = 16'h0200;
   localparam logic [15:0] F_MDROUT = 16'h0100;
   localparam logic [15:0] F_HIIN   = 16'h0080;
   localparam logic [15:0] F_HIOUT  = 16'h0040;
   localparam logic [15:0] F_LOIN   = 16'h0020;
   localparam logic [15:0] F_LOOUT  = 16'h0010;
   localparam logic [15:0] F_INCPC  = 16'h0008;
   localparam logic [15:0] F_ZHIGH  = 16'h0004;
   localparam logic [15:0] F_ZLOW   = 16'h0002;
   localparam logic [15:0] F_READ   = 16'h0001;

   logic clock;
   logic clear;
   int   total;
   int   passed;
   int   failed;

   logic [52:0] obs;
   logic [52:0] e_t0;
   logic [52:0] e_t1;
   logic [52:0] e_t2;
   logic [52:0] e_halt;

   control_sequencer_if bus ();

   control_sequencer dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign obs = {bus.Rin, bus.Rout,
                 bus.PCin, bus.PCout, bus.IRin, bus.Yin,
                 bus.Zin, bus.MARin, bus.MDRin, bus.MDRout,
                 bus.HIin, bus.HIout, bus.LOin, bus.LOout,
                 bus.IncPC, bus.Zhighout, bus.Zlowout,
                 bus.Read, bus.ALUselect, bus.Run};

   function automatic logic [52:0] mk(
      input logic [15:0] rin,
      input logic [15:0] rout,
      input logic [15:0] f,
      input logic [3:0]  alu,
      input logic        run
   );
      return {rin, rout, f, alu, run};
   endfunction

   task automatic chk(input string tag, input logic [52:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      total  = 0;
      passed = 0;
      failed = 0;
      e_t0   = mk(16'h0, 16'h0,
                  F_PCOUT | F_MARIN | F_INCPC | F_ZIN, 4'h0, 1'b1);
      e_t1   = mk(16'h0, 16'h0,
                  F_ZLOW | F_PCIN | F_READ | F_MDRIN, 4'h0, 1'b1);
      e_t2   = mk(16'h0, 16'h0, F_MDROUT | F_IRIN, 4'h0, 1'b1);
      e_halt = mk(16'h0, 16'h0, 16'h0, 4'h0, 1'b0);

      // and r1, r2, r3
      bus.IR   = 32'h28918000;
      bus.Stop = 1'b0;
      clear    = 1'b1;
      repeat (2) @(negedge clock);
      chk("reset_t0", e_t0);
      clear = 1'b0;
      step(); chk("and_t1", e_t1);
      step(); chk("and_t2", e_t2);
      step(); chk("and_t3", mk(16'h0, 16'h0004, F_YIN, 4'h0, 1'b1));
      step(); chk("and_t4", mk(16'h0, 16'h0008, F_ZIN, 4'b0110, 1'b1));
      step(); chk("and_t5", mk(16'h0002, 16'h0, F_ZLOW, 4'h0, 1'b1));
      step(); chk("and_t0", e_t0);

      // add r4, r5, r6
      bus.IR = {5'b00011, 4'd4, 4'd5, 4'd6, 15'd0};
      step(); step(); step();
      chk("add_t3", mk(16'h0, 16'h0020, F_YIN, 4'h0, 1'b1));
      step(); chk("add_t4", mk(16'h0, 16'h0040, F_ZIN, 4'b0001, 1'b1));
      step(); chk("add_t5", mk(16'h0010, 16'h0, F_ZLOW, 4'h0, 1'b1));
      step(); chk("add_t0", e_t0);

      // undefined opcode
      bus.IR = {5'b11111, 4'd7, 4'd8, 4'd9, 15'd0};
      step(); chk("nop_t1", e_t1);
      step(); chk("nop_t2", e_t2);
      step(); chk("nop_t0", e_t0);
      step(); chk("nop_t1b", e_t1);

      // mul r2, r3
      bus.IR = {5'b01111, 4'd2, 4'd3, 4'd0, 15'd0};
      step(); chk("mul_t2", e_t2);
      step();
`ifdef MULDIV_EN
      chk("mul_t3", mk(16'h0, 16'h0004, F_YIN, 4'h0, 1'b1));
      step(); chk("mul_t4", mk(16'h0, 16'h0008, F_ZIN, 4'b1010, 1'b1));
      step(); chk("mul_t5", mk(16'h0, 16'h0, F_LOIN | F_ZLOW, 4'h0, 1'b1));
      step(); chk("mul_t6", mk(16'h0, 16'h0, F_HIIN | F_ZHIGH, 4'h0, 1'b1));
      step(); chk("mul_t0", e_t0);
`else
      chk("mul_nop_t0", e_t0);
`endif

      // Stop raised early is only acted on at T2
      bus.IR   = {5'b00011, 4'd4, 4'd5, 4'd6, 15'd0};
      bus.Stop = 1'b1;
      step(); chk("stop_t1", e_t1);
      step(); chk("stop_t2", e_t2);
      step(); chk("halt", e_halt);
      bus.Stop = 1'b0;
      step(); step(); chk("halt_hold", e_halt);
      clear = 1'b1;
      #1 chk("clr_halt", e_t0);
      clear = 1'b0;
      @(negedge clock); chk("clr_halt_t1", e_t1);

      // Stop in T3 ignored, then clear mid-T4
      bus.IR = 32'h28918000;
      step(); chk("and2_t2", e_t2);
      step(); chk("and2_t3", mk(16'h0, 16'h0004, F_YIN, 4'h0, 1'b1));
      bus.Stop = 1'b1;
      step(); chk("stop_t3_ign", mk(16'h0, 16'h0008, F_ZIN, 4'b0110, 1'b1));
      bus.Stop = 1'b0;
      #2 clear = 1'b1;
      #1 chk("clr_t4", e_t0);
      #1 clear = 1'b0;
      @(negedge clock); chk("clr_t4_t1", e_t1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
